s38584_sel_sched: RTL and testbench

Round-robin scheduler that shares the s38584 select-mux update register among NREQ requesters. Each requester supplies a 4-bit select code, which drives the one-hot-style selector lines of the shared mux cone (g6381/g6395/g6336/g6351 group). The block sequences a transaction for each grant: arbitrate, present the code, wait for the datapath qualifier (the g4688-class gate), then pulse the update enable. The global enable g35 freezes the block exactly as it freezes the datapath.

---
 rtl/s38584_sel_sched.sv | 194 +++++++++++++++++++
 tb/tb_s38584_sel_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s38584_sel_sched.sv
// s38584_sel_sched
// Round-robin scheduler sharing the s38584 select-mux update register among
// NREQ requesters. Each grant runs one transaction: arbitrate, present the
// winner's 4-bit select code, give the mux cone one settle cycle, wait for
// the datapath qualifier (bounded by TMO cycles), then pulse the update enable.
// g35 low freezes the block exactly as it freezes the datapath.
//
// Ports:
//   CK       clock, rising edge
//   RN       asynchronous active-low reset
//   g35      global enable (0 = freeze)
//   req      per-requester level request
//   req_sel  per-requester select code, CBW bits per requester
//   qual_ok  datapath qualifier, 1 = update permitted
//   gnt      one-hot grant, held for the whole transaction
//   ack      one-cycle completion pulse to the granted requester
//   nack     one-cycle abort pulse (timeout, or bad parity when enabled)
//   sel_code select code presented to the mux cone (holds between grants)
//   upd_en   one-cycle update strobe to the shared register
//   busy     high whenever the scheduler is not idle
//   perr     (SEL_SCHED_PARITY_EN only) one-cycle parity-error pulse
//
// Optional feature macro: SEL_SCHED_PARITY_EN -- each requester code carries
// an even-parity bit at [5i+4]; a winner with bad parity is refused with
// nack/perr and never reaches the mux cone.
module s38584_sel_sched #(
  parameter int NREQ = 4,
  parameter int TMO  = 16,
  parameter int CW   = 5,
`ifdef SEL_SCHED_PARITY_EN
  localparam int CBW = 5
`else
  localparam int CBW = 4
`endif
) (
  input  logic                CK,
  input  logic                RN,
  input  logic                g35,
  input  logic [NREQ-1:0]     req,
  input  logic [CBW*NREQ-1:0] req_sel,
  input  logic                qual_ok,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     nack,
  output logic [3:0]          sel_code,
`ifdef SEL_SCHED_PARITY_EN
  output logic                perr,
`endif
  output logic                upd_en,
  output logic                busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, UPDATE} state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic [NREQ-1:0] nack_reg, nack_next;
  logic [3:0]      sel_reg, sel_next;
  logic            upd_reg, upd_next;
  logic            perr_reg, perr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IW-1:0]   rr_reg, rr_next;
  logic [IW-1:0]   idx_reg, idx_next;

  logic [3:0]      code [NREQ];
  logic [NREQ-1:0] code_bad;
  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] cand;
  logic [IW-1:0]   win;
  logic            win_bad;

  // Per-requester code slices; hi_mask marks requesters after rr_ptr so the
  // scan starts at rr_ptr+1 and wraps to the unmasked request vector.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign code[gi]    = req_sel[CBW*gi +: 4];
    assign hi_mask[gi] = (IW'(gi) > rr_reg);
`ifdef SEL_SCHED_PARITY_EN
    assign code_bad[gi] = ^req_sel[CBW*gi +: 5];
`else
    assign code_bad[gi] = 1'b0;
`endif
  end

  always_comb begin
    cand = (|(req & hi_mask)) ? (req & hi_mask) : req;
    win  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[k]) win = IW'(k);
    end
  end

  assign win_bad = code_bad[win];

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    rr_next    = rr_reg;
    idx_next   = idx_reg;
    ack_next   = '0;
    nack_next  = '0;
    upd_next   = 1'b0;
    perr_next  = 1'b0;
    if (g35) begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            if (win_bad) begin
              // Refused grant: treated like an abort so the requester loses priority.
              nack_next[win] = 1'b1;
              perr_next      = 1'b1;
              rr_next        = win;
            end else begin
              gnt_next      = '0;
              gnt_next[win] = 1'b1;
              sel_next      = code[win];
              idx_next      = win;
              state_next    = SETUP;
            end
          end
        end
        SETUP: begin
          cnt_next   = '0;
          state_next = WAIT;
        end
        WAIT: begin
          if (qual_ok) begin
            // Strobes are registered, so they rise together with entry to UPDATE.
            upd_next          = 1'b1;
            ack_next[idx_reg] = 1'b1;
            state_next        = UPDATE;
          end else if (cnt_reg == CW'(TMO - 1)) begin
            nack_next[idx_reg] = 1'b1;
            gnt_next           = '0;
            rr_next            = idx_reg;
            state_next         = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        UPDATE: begin
          gnt_next   = '0;
          rr_next    = idx_reg;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      nack_reg  <= '0;
      sel_reg   <= '0;
      upd_reg   <= 1'b0;
      perr_reg  <= 1'b0;
      cnt_reg   <= '0;
      rr_reg    <= IW'(NREQ - 1);
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      nack_reg  <= nack_next;
      sel_reg   <= sel_next;
      upd_reg   <= upd_next;
      perr_reg  <= perr_next;
      cnt_reg   <= cnt_next;
      rr_reg    <= rr_next;
      idx_reg   <= idx_next;
    end
  end

  assign gnt      = gnt_reg;
  assign ack      = ack_reg;
  assign nack     = nack_reg;
  assign sel_code = sel_reg;
  assign upd_en   = upd_reg;
  assign busy     = (state_reg != IDLE);
`ifdef SEL_SCHED_PARITY_EN
  assign perr     = perr_reg;
`else
  logic unused_perr;
  assign unused_perr = perr_reg;
`endif

endmodule

// File: tb/tb_s38584_sel_sched.sv
// Testbench for s38584_sel_sched: directed stimulus, a transaction-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_s38584_sel_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 16;
`ifdef SEL_SCHED_PARITY_EN
  localparam int SW = 5;
`else
  localparam int SW = 4;
`endif

  logic CK = 1'b0;
  logic RN = 1'b0;
  logic g35 = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [SW*NREQ-1:0] req_sel = '0;
  logic qual_ok = 1'b0;
  logic [NREQ-1:0] gnt, ack, nack;
  logic [3:0] sel_code;
  logic upd_en, busy;
`ifdef SEL_SCHED_PARITY_EN
  logic perr;
`endif

  s38584_sel_sched #(.NREQ(NREQ), .TMO(TMO), .CW(5)) dut (
    .CK(CK), .RN(RN), .g35(g35), .req(req), .req_sel(req_sel),
    .qual_ok(qual_ok), .gnt(gnt), .ack(ack), .nack(nack),
    .sel_code(sel_code),
`ifdef SEL_SCHED_PARITY_EN
    .perr(perr),
`endif
    .upd_en(upd_en), .busy(busy)
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [SW*NREQ-1:0] mk_sel(input logic [3:0] c0, c1, c2, c3);
    logic [SW*NREQ-1:0] v;
    logic [3:0] c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      v[SW*i +: 4] = c[i];
`ifdef SEL_SCHED_PARITY_EN
      v[SW*i + 4] = ^c[i];
`endif
    end
    return v;
  endfunction

  // Reference model: a transaction either does not exist, is settling, is
  // waiting (with a count of cycles waited), or is finishing after its update.
  bit m_busy, m_settle, m_fin, m_perr, m_upd;
  int m_who, m_waited, m_ptr;
  logic [3:0] m_sel;
  logic [NREQ-1:0] m_ack, m_nack;

  task automatic model_step();
    int w;
    logic [SW-1:0] slot;
    if (!RN) begin
      m_busy = 0; m_settle = 0; m_fin = 0; m_waited = 0; m_ptr = NREQ - 1;
      m_who = 0; m_sel = '0; m_ack = '0; m_nack = '0; m_upd = 0; m_perr = 0;
      return;
    end
    m_ack = '0; m_nack = '0; m_upd = 0; m_perr = 0;
    if (!g35) return;
    if (!m_busy) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        slot = req_sel[SW*w +: SW];
        if (SW == 5 && (^slot)) begin
          m_nack[w] = 1'b1; m_perr = 1; m_ptr = w;
        end else begin
          m_busy = 1; m_settle = 1; m_who = w; m_sel = slot[3:0];
        end
      end
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0; m_ptr = m_who;
    end else if (m_settle) begin
      m_settle = 0; m_waited = 0;
    end else if (qual_ok) begin
      m_fin = 1; m_upd = 1; m_ack[m_who] = 1'b1;
    end else if (m_waited == TMO - 1) begin
      m_nack[m_who] = 1'b1; m_busy = 0; m_ptr = m_who;
    end else begin
      m_waited++;
    end
  endtask

  initial forever begin
    @(posedge CK or negedge RN);
    model_step();
  end

  initial forever begin
    @(posedge CK);
    cyc++;
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge CK);
    if (chk_on) begin
      chk("cyc_gnt", gnt, m_busy ? (32'd1 << m_who) : 32'd0);
      chk("cyc_ack", ack, m_ack);
      chk("cyc_nack", nack, m_nack);
      chk("cyc_sel", sel_code, m_sel);
      chk("cyc_upd", upd_en, m_upd);
      chk("cyc_busy", busy, m_busy);
`ifdef SEL_SCHED_PARITY_EN
      chk("cyc_perr", perr, m_perr);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  int last_upd;

  initial begin
    req_sel = mk_sel(4'h1, 4'h2, 4'h3, 4'h4);
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel_code, 0);
    chk("rst_busy", busy, 0);
    @(negedge CK);
    RN = 1'b1;
    chk_on = 1;

    // Asynchronous reset in the middle of WAIT
    req = 4'b0010; qual_ok = 0;
    tick();
    chk("rw_gnt", gnt, 4'b0010);
    chk("rw_sel", sel_code, 4'h2);
    req = 0;
    tick(); tick(); tick();
    chk("rw_busy", busy, 1);
    #2 RN = 1'b0;
    #1;
    chk("ra_gnt", gnt, 0);
    chk("ra_sel", sel_code, 0);
    chk("ra_busy", busy, 0);
    chk("ra_upd", upd_en, 0);
    @(negedge CK);
    RN = 1'b1; req = 4'b1111; qual_ok = 1;

    // Rotation with all requesting: 0,1,2,3,0, updates 4 cycles apart
    last_upd = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("rot_gnt", gnt, 32'd1 << (t % 4));
      chk("rot_sel", sel_code, (t % 4) + 1);
      if (t == 4) req = 0;
      tick(); tick();
      chk("rot_upd", upd_en, 1);
      chk("rot_ack", ack, 32'd1 << (t % 4));
      if (t > 0) chk("rot_gap", cyc - last_upd, 4);
      last_upd = cyc;
      tick();
      chk("rot_end", gnt, 0);
    end

    // Single request, qual already high
    req = 4'b0100; req_sel = mk_sel(4'h1, 4'h2, 4'hA, 4'h4); qual_ok = 1;
    tick();
    chk("one_gnt", gnt, 4'b0100);
    chk("one_sel", sel_code, 4'hA);
    req = 0; req_sel = mk_sel(4'h1, 4'h2, 4'h3, 4'h4);
    tick();
    chk("one_upd_e1", upd_en, 0);
    tick();
    chk("one_upd_e2", upd_en, 1);
    chk("one_ack", ack, 4'b0100);
    tick();
    chk("one_gnt_e3", gnt, 0);
    chk("one_upd_e3", upd_en, 0);
    chk("one_sel_hold", sel_code, 4'hA);

    // Timeout: nack 16 cycles after WAIT entry, then priority rotates past 2
    req = 4'b0100; qual_ok = 0;
    tick();
    chk("to_gnt", gnt, 4'b0100);
    req = 0;
    tick();
    for (int n = 1; n <= TMO; n++) begin
      tick();
      chk("to_upd", upd_en, 0);
      chk("to_nack", nack, (n == TMO) ? 4'b0100 : 4'b0000);
    end
    chk("to_gnt_clr", gnt, 0);
    req = 4'b1100; qual_ok = 1;
    tick();
    chk("to_next", gnt, 4'b1000);
    req = 0;
    tick(); tick();
    chk("to_ack", ack, 4'b1000);
    tick();

    // Freeze for 5 cycles in WAIT with qual high
    req = 4'b0001; req_sel = mk_sel(4'h9, 4'h2, 4'h3, 4'h4);
    tick();
    chk("fz_gnt", gnt, 4'b0001);
    req = 0;
    tick();
    g35 = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("fz_upd", upd_en, 0);
      chk("fz_hold", gnt, 4'b0001);
    end
    g35 = 1;
    tick();
    chk("fz_upd_go", upd_en, 1);
    chk("fz_ack", ack, 4'b0001);
    tick();
    chk("fz_end", gnt, 0);
    chk("fz_sel", sel_code, 4'h9);

`ifdef SEL_SCHED_PARITY_EN
    // Code 4'b0001 with parity bit 0 on requester 1
    req_sel = mk_sel(4'h9, 4'h1, 4'h3, 4'h4);
    req_sel[SW + 4] = 1'b0;
    req = 4'b0010;
    tick();
    chk("par_perr", perr, 1);
    chk("par_nack", nack, 4'b0010);
    chk("par_gnt", gnt, 0);
    chk("par_sel", sel_code, 4'h9);
    req = 0;
    tick();
    chk("par_upd", upd_en, 0);
    chk("par_perr_clr", perr, 0);
`endif

    tick(); tick();
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
